// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Holds the reset PC, the NOP bubble encoding and the fetch FSM states.
package instr_fetch_pkg;

   localparam logic [4:0]  INSTR_OPCODE5_NOP = 5'b00001;
   localparam logic [15:0] NOP_INSTR         = {INSTR_OPCODE5_NOP, 11'b0};
   localparam logic [15:0] RESET_PC          = 16'h0000;

   typedef enum logic {
      FETCH    = 1'b0,
      BUFFERED = 1'b1
   } fetch_state_t;

   // A redirect left pending by a stalled delay slot beats a fresh branch
   function automatic logic [15:0] next_pc(input logic        redir_v,
                                           input logic [15:0] redir_pc,
                                           input logic        branch,
                                           input logic [15:0] new_pc,
                                           input logic [15:0] pc);
      if (redir_v)
         return redir_pc;
      else if (branch)
         return new_pc;
      else
         return pc + 16'd1;
   endfunction

endpackage

// File: rtl/instr_fetch_skid_buf.sv
// One-entry holding register for a fetch word that returned while the
// pipeline was paused.
module fetch_skid_buf
   import instr_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        load,
   input  logic        drain,
   input  logic [15:0] load_data,
   output logic [15:0] buf_data,
   output logic        buf_valid
);

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_data  <= 16'h0000;
         buf_valid <= 1'b0;
      end else if (flush) begin
         buf_valid <= 1'b0;
      end else if (load) begin
         buf_data  <= load_data;
         buf_valid <= 1'b1;
      end else if (drain) begin
         buf_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage and IF/ID pipeline register.
//
// state    | meaning
// FETCH    | request outstanding at pc; capture on ack
// BUFFERED | word for pc held in skid buffer while paused; no request
module instr_fetch
   import instr_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ifi_pause,
   input  logic        ifi_branch,
   input  logic [15:0] ifi_new_pc,
   input  logic        ifi_int,
   input  logic [15:0] ifi_int_pc,
   output logic        ifo_mem_req,
   output logic [15:0] ifo_mem_addr,
   input  logic        ifi_mem_ack,
   input  logic [15:0] ifi_mem_data,
   output logic [15:0] ifo_addr,
   output logic [15:0] ifo_instr,
   output logic        ifo_valid
);

   fetch_state_t state;
   logic [15:0]  pc;
   logic         redir_v;
   logic [15:0]  redir_pc;
   logic [15:0]  npc;
   logic [15:0]  buf_data;
   logic         buf_valid;
   logic         buf_load;
   logic         buf_drain;

   assign ifo_mem_req  = !rst && (state == FETCH);
   assign ifo_mem_addr = pc;
   assign npc          = next_pc(redir_v, redir_pc, ifi_branch, ifi_new_pc, pc);
   assign buf_load     = (state == FETCH) && ifi_mem_ack && ifi_pause;
   assign buf_drain    = (state == BUFFERED) && !ifi_pause;

   fetch_skid_buf u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (ifi_int),
      .load      (buf_load),
      .drain     (buf_drain),
      .load_data (ifi_mem_data),
      .buf_data  (buf_data),
      .buf_valid (buf_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FETCH;
         pc        <= RESET_PC;
         redir_v   <= 1'b0;
         redir_pc  <= 16'h0000;
         ifo_addr  <= 16'h0000;
         ifo_instr <= NOP_INSTR;
         ifo_valid <= 1'b0;
      end else if (ifi_int) begin
         state     <= FETCH;
         pc        <= ifi_int_pc;
         redir_v   <= 1'b0;
         ifo_addr  <= 16'h0000;
         ifo_instr <= NOP_INSTR;
         ifo_valid <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (ifi_mem_ack) begin
                  if (!ifi_pause) begin
                     ifo_addr  <= pc;
                     ifo_instr <= ifi_mem_data;
                     ifo_valid <= 1'b1;
                     pc        <= npc;
                     redir_v   <= 1'b0;
                  end else begin
                     state <= BUFFERED;
                  end
               end else if (!ifi_pause) begin
                  ifo_addr  <= pc;
                  ifo_instr <= NOP_INSTR;
                  ifo_valid <= 1'b0;
                  // Delay slot still outstanding: remember the target until it lands
                  if (ifi_branch) begin
                     redir_v  <= 1'b1;
                     redir_pc <= ifi_new_pc;
                  end
               end
            end
            BUFFERED: begin
               if (!ifi_pause && buf_valid) begin
                  ifo_addr  <= pc;
                  ifo_instr <= buf_data;
                  ifo_valid <= 1'b1;
                  pc        <= npc;
                  redir_v   <= 1'b0;
                  state     <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: scripted per-cycle vector table with a scoreboard
// queue for IF/ID, then a randomized pause/wait-state streaming run.
module tb_instr_fetch;

   localparam logic [15:0] NOP = 16'h0800;

   logic        clk;
   logic        rst;
   logic        ifi_pause;
   logic        ifi_branch;
   logic [15:0] ifi_new_pc;
   logic        ifi_int;
   logic [15:0] ifi_int_pc;
   logic        ifo_mem_req;
   logic [15:0] ifo_mem_addr;
   logic        ifi_mem_ack;
   logic [15:0] ifi_mem_data;
   logic [15:0] ifo_addr;
   logic [15:0] ifo_instr;
   logic        ifo_valid;

   int checks   = 0;
   int failures = 0;

   instr_fetch dut (
      .clk          (clk),
      .rst          (rst),
      .ifi_pause    (ifi_pause),
      .ifi_branch   (ifi_branch),
      .ifi_new_pc   (ifi_new_pc),
      .ifi_int      (ifi_int),
      .ifi_int_pc   (ifi_int_pc),
      .ifo_mem_req  (ifo_mem_req),
      .ifo_mem_addr (ifo_mem_addr),
      .ifi_mem_ack  (ifi_mem_ack),
      .ifi_mem_data (ifi_mem_data),
      .ifo_addr     (ifo_addr),
      .ifo_instr    (ifo_instr),
      .ifo_valid    (ifo_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Zero-wait memory: mem[a] = a | 16'h4000
   always_comb ifi_mem_data = ifo_mem_addr | 16'h4000;

   typedef struct {
      logic        rst, ack, pause, br;
      logic [15:0] npc;
      logic        intr;
      logic [15:0] ipc;
      logic        ereq;
      logic [15:0] emaddr, ea, ei;
      logic        ev;
   } vec_t;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] i;
      logic        v;
   } idf_t;

   vec_t vecs[$];
   idf_t sb_q[$];

   function automatic vec_t mk(logic r, logic ack, logic pause, logic br, logic [15:0] npc,
                               logic intr, logic [15:0] ipc, logic ereq, logic [15:0] emaddr,
                               logic [15:0] ea, logic [15:0] ei, logic ev);
      vec_t v;
      v.rst = r; v.ack = ack; v.pause = pause; v.br = br; v.npc = npc;
      v.intr = intr; v.ipc = ipc; v.ereq = ereq; v.emaddr = emaddr;
      v.ea = ea; v.ei = ei; v.ev = ev;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s @%0d: got %h expected %h", name, idx, got, exp);
      end
   endtask

   initial begin
      idf_t   e;
      idf_t   prev;
      logic   pz;
      logic [15:0] exp_next;

      //   rst ack pse br npc       int ipc       req maddr     id_addr   id_instr  v
      vecs.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, NOP,      0));
      vecs.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, NOP,      0));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h4000, 1));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0001, 16'h0001, 16'h4001, 1));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 16'h0002, 16'h4002, 1));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0003, 16'h0003, 16'h4003, 1));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 16'h0004, 16'h4004, 1));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0005, 16'h0005, 16'h4005, 1));
      // branch at 5 -> slot 6, then 0x20
      vecs.push_back(mk(0, 1, 0, 1, 16'h0020, 0, 16'h0000, 1, 16'h0006, 16'h0006, 16'h4006, 1));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0020, 16'h0020, 16'h4020, 1));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0021, 16'h0021, 16'h4021, 1));
      // branch at 0x21 while memory withholds ack 3 cycles
      vecs.push_back(mk(0, 0, 0, 1, 16'h0040, 0, 16'h0000, 1, 16'h0022, 16'h0022, NOP,      0));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0022, 16'h0022, NOP,      0));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0022, 16'h0022, NOP,      0));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0022, 16'h0022, 16'h4022, 1));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0040, 16'h0040, 16'h4040, 1));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0041, 16'h0041, 16'h4041, 1));
      // ack during pause, paused 2 more cycles, release without new request
      vecs.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0042, 16'h0041, 16'h4041, 1));
      vecs.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0041, 16'h4041, 1));
      vecs.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0041, 16'h4041, 1));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0042, 16'h4042, 1));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0043, 16'h0043, 16'h4043, 1));
      // branch ignored under pause
      vecs.push_back(mk(0, 0, 1, 1, 16'h0099, 0, 16'h0000, 1, 16'h0044, 16'h0043, 16'h4043, 1));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0044, 16'h0044, 16'h4044, 1));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0045, 16'h0045, 16'h4045, 1));
      // pending redirect, then buffered, then interrupt discards both
      vecs.push_back(mk(0, 0, 0, 1, 16'h0070, 0, 16'h0000, 1, 16'h0046, 16'h0046, NOP,      0));
      vecs.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0046, 16'h0046, NOP,      0));
      vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 1, 16'h0008, 0, 16'h0000, 16'h0000, NOP,      0));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0008, 16'h0008, 16'h4008, 1));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0009, 16'h0009, 16'h4009, 1));
      // interrupt drops same-cycle ack; PC wrap at 16'hFFFF
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'hFFFE, 1, 16'h000A, 16'h0000, NOP,      0));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'hFFFE, 16'hFFFE, 16'hFFFE, 1));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h4000, 1));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0001, 16'h0001, 16'h4001, 1));
      // mid-run reset
      vecs.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, NOP,      0));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h4000, 1));
      // branch on the pause-release cycle from BUFFERED
      vecs.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0001, 16'h0000, 16'h4000, 1));
      vecs.push_back(mk(0, 1, 0, 1, 16'h0100, 0, 16'h0000, 0, 16'h0000, 16'h0001, 16'h4001, 1));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0100, 16'h0100, 16'h4100, 1));

      for (int n = 0; n < vecs.size(); n++) begin
         rst         = vecs[n].rst;
         ifi_mem_ack = vecs[n].ack;
         ifi_pause   = vecs[n].pause;
         ifi_branch  = vecs[n].br;
         ifi_new_pc  = vecs[n].npc;
         ifi_int     = vecs[n].intr;
         ifi_int_pc  = vecs[n].ipc;
         #1;
         chk("mem_req", n, {31'd0, ifo_mem_req}, {31'd0, vecs[n].ereq});
         if (vecs[n].ereq)
            chk("mem_addr", n, {16'd0, ifo_mem_addr}, {16'd0, vecs[n].emaddr});
         sb_q.push_back('{a: vecs[n].ea, i: vecs[n].ei, v: vecs[n].ev});
         @(posedge clk);
         #1;
         e = sb_q.pop_front();
         chk("id_addr", n, {16'd0, ifo_addr}, {16'd0, e.a});
         chk("id_instr", n, {16'd0, ifo_instr}, {16'd0, e.i});
         chk("id_valid", n, {31'd0, ifo_valid}, {31'd0, e.v});
         @(negedge clk);
      end

      // Random pause / wait states: every instruction reaches ID once, in order
      exp_next   = 16'h0101;
      ifi_branch = 1'b0;
      ifi_int    = 1'b0;
      for (int c = 0; c < 300; c++) begin
         pz          = ($urandom_range(0, 3) == 0);
         ifi_pause   = pz;
         ifi_mem_ack = ($urandom_range(0, 2) != 0);
         prev        = '{a: ifo_addr, i: ifo_instr, v: ifo_valid};
         @(posedge clk);
         #1;
         if (pz) begin
            chk("pause_hold", 1000 + c, {ifo_addr, ifo_instr}, {prev.a, prev.i});
         end else if (ifo_valid) begin
            chk("stream_addr", 1000 + c, {16'd0, ifo_addr}, {16'd0, exp_next});
            chk("stream_instr", 1000 + c, {16'd0, ifo_instr}, {16'd0, exp_next | 16'h4000});
            exp_next = exp_next + 16'd1;
         end else begin
            chk("bubble_instr", 1000 + c, {16'd0, ifo_instr}, {16'd0, NOP});
         end
         @(negedge clk);
      end
      chk("stream_progress", 0, {31'd0, (exp_next - 16'h0101) > 16'd30}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
